// File: rtl/clock_display_pkg.sv
// Shared definitions for the HH.MM.SS multiplexed 7-segment display driver.
// Holds the digit count, the high-true segment patterns ({g,f,e,d,c,b,a}),
// the digit-index encoding and small helpers for the scan and the BCD split.
package clock_display_pkg;

    localparam int unsigned DIGITS = 6;

    // Scan position; the value is also the Digit_En bit that gets selected.
    typedef enum logic [2:0] {
        DIG_SEC_ONES  = 3'd0,
        DIG_SEC_TENS  = 3'd1,
        DIG_MIN_ONES  = 3'd2,
        DIG_MIN_TENS  = 3'd3,
        DIG_HOUR_ONES = 3'd4,
        DIG_HOUR_TENS = 3'd5
    } digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0111111, // 0
        7'b0000110, // 1
        7'b1011011, // 2
        7'b1001111, // 3
        7'b1100110, // 4
        7'b1101101, // 5
        7'b1111101, // 6
        7'b0000111, // 7
        7'b1111111, // 8
        7'b1101111  // 9
    };

    function automatic digit_idx_t next_digit(input digit_idx_t d);
        case (d)
            DIG_SEC_ONES:  return DIG_SEC_TENS;
            DIG_SEC_TENS:  return DIG_MIN_ONES;
            DIG_MIN_ONES:  return DIG_MIN_TENS;
            DIG_MIN_TENS:  return DIG_HOUR_ONES;
            DIG_HOUR_ONES: return DIG_HOUR_TENS;
            default:       return DIG_SEC_ONES;
        endcase
    endfunction

    // Comparator ladder instead of a divider; exact for 0..63.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] t;
        t = {2'b00, tens_of(v)};
        return 4'(v - t * 6'd10);
    endfunction

endpackage

// File: rtl/clock_display_seg7_encoder.sv
// seg7_encoder: combinational digit-to-segment lookup, high-true output.
//   digit : 4-bit decimal digit (values above 9 render blank)
//   blank : force all segments off
//   dash  : force segment g only; overrides blank
//   seg   : {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_encoder
    import clock_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank) begin
            for (int unsigned i = 0; i < 10; i++) begin
                if (digit == 4'(i)) seg = SEG_DIGIT[i];
            end
        end
    end

endmodule

// File: rtl/clock_display_driver.sv
// clock_display_driver: six-digit multiplexed 7-segment driver for HH.MM.SS.
// A Load strobe snapshots the time; the snapshot is range-checked, split into
// decimal digits and scanned one digit per REFRESH_DIV-cycle slot, with the
// first cycle of every slot blanked to prevent ghosting.
//   Clock     : rising-edge clock
//   Reset     : synchronous, active-high
//   Hour/Min/Sec : binary time inputs, captured when Load=1
//   Load      : capture strobe
//   Seg       : segments {g,f,e,d,c,b,a}
//   Dp        : decimal point (HH.MM.SS separator, blinks with Sec bit0)
//   Digit_En  : one-hot digit select, bit 5 = hour tens
//   Range_Err : snapshot holds an out-of-range time
// Seg, Dp and Digit_En are low-true when ACTIVE_LOW=1.
module clock_display_driver
    import clock_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [4:0] Hour,
    input  logic [5:0] Min,
    input  logic [5:0] Sec,
    input  logic       Load,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [5:0] Digit_En,
    output logic       Range_Err
);

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [6:0]  SEG_INV  = {7{ACTIVE_LOW}};
    localparam logic [5:0]  EN_INV   = {6{ACTIVE_LOW}};

    logic [15:0] count;
    logic [15:0] count_next;
    digit_idx_t  idx;
    digit_idx_t  idx_next;

    logic [4:0]  snap_h;
    logic [5:0]  snap_m;
    logic [5:0]  snap_s;

    logic [3:0]  digit;
    logic        blank;
    logic        guard;
    logic [6:0]  enc_seg;
    logic [6:0]  seg_hi;
    logic [5:0]  en_hi;
    logic        dp_hi;

    // Scan timing: index only moves on the counter wrap, never on Load.
    always_comb begin
        count_next = count + 16'd1;
        idx_next   = idx;
        if (count == CNT_LAST) begin
            count_next = '0;
            idx_next   = next_digit(idx);
        end
    end

    always_comb begin
        case (idx)
            DIG_HOUR_TENS: digit = tens_of({1'b0, snap_h});
            DIG_HOUR_ONES: digit = ones_of({1'b0, snap_h});
            DIG_MIN_TENS:  digit = tens_of(snap_m);
            DIG_MIN_ONES:  digit = ones_of(snap_m);
            DIG_SEC_TENS:  digit = tens_of(snap_s);
            default:       digit = ones_of(snap_s);
        endcase
        blank = (idx == DIG_HOUR_TENS) && (digit == 4'd0);
    end

    seg7_encoder u_enc (
        .digit (digit),
        .blank (blank),
        .dash  (Range_Err),
        .seg   (enc_seg)
    );

    // Outputs for the next cycle; counter==0 marks the guard cycle.
    always_comb begin
        guard  = (count == '0);
        seg_hi = SEG_BLANK;
        en_hi  = '0;
        dp_hi  = 1'b0;
        if (!guard) begin
            seg_hi = enc_seg;
            en_hi  = 6'(1) << idx;
            dp_hi  = ((idx == DIG_HOUR_ONES) || (idx == DIG_MIN_ONES)) && !snap_s[0];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count     <= '0;
            idx       <= DIG_SEC_ONES;
            snap_h    <= '0;
            snap_m    <= '0;
            snap_s    <= '0;
            Range_Err <= 1'b0;
            Seg       <= SEG_BLANK ^ SEG_INV;
            Dp        <= ACTIVE_LOW;
            Digit_En  <= EN_INV;
        end else begin
            count <= count_next;
            idx   <= idx_next;
            if (Load) begin
                snap_h    <= Hour;
                snap_m    <= Min;
                snap_s    <= Sec;
                Range_Err <= (Hour > 5'd23) || (Min > 6'd59) || (Sec > 6'd59);
            end
            Seg      <= seg_hi ^ SEG_INV;
            Dp       <= dp_hi ^ ACTIVE_LOW;
            Digit_En <= en_hi ^ EN_INV;
        end
    end

endmodule

// File: tb/tb_clock_display_driver.sv
// Testbench for clock_display_driver (REFRESH_DIV=4). Two instances share the
// stimulus: one high-true, one low-true. Every cycle both are compared against
// an arithmetic model (slot = edges since reset / DIV, digit via /10 and %10);
// a vector table and directed sequences add hand-written expectations.
module tb_clock_display_driver;

    localparam int DIV = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Load  = 1'b0;
    logic [4:0] Hour  = '0;
    logic [5:0] Min   = '0;
    logic [5:0] Sec   = '0;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1, err0, err1;
    logic [5:0] en0, en1;

    clock_display_driver #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_hi (
        .Clock(Clock), .Reset(Reset), .Hour(Hour), .Min(Min), .Sec(Sec),
        .Load(Load), .Seg(seg0), .Dp(dp0), .Digit_En(en0), .Range_Err(err0)
    );

    clock_display_driver #(.REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_lo (
        .Clock(Clock), .Reset(Reset), .Hour(Hour), .Min(Min), .Sec(Sec),
        .Load(Load), .Seg(seg1), .Dp(dp1), .Digit_En(en1), .Range_Err(err1)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] SEGTAB [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state: non-reset edges since reset, snapshot, error flag.
    int n  = 0;
    int sh = 0, sm = 0, ss = 0;
    bit serr = 1'b0;

    logic [6:0] e_seg;
    logic [5:0] e_en;
    logic       e_dp, e_err;

    typedef struct {
        logic       rst;
        logic       ld;
        int         h, m, s;
        logic [5:0] en;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t tbl [31];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic rst, input logic ld, input int h, input int m, input int s);
        int c, idx, field, d;
        Reset = rst;
        Load  = ld;
        Hour  = 5'(h);
        Min   = 6'(m);
        Sec   = 6'(s);
        c   = n % DIV;
        idx = (n / DIV) % 6;
        e_seg = '0;
        e_en  = '0;
        e_dp  = 1'b0;
        if (!rst && c != 0) begin
            field = (idx >= 4) ? sh : (idx >= 2) ? sm : ss;
            d     = (idx % 2 == 1) ? field / 10 : field % 10;
            e_en  = 6'(1 << idx);
            if (serr)                 e_seg = 7'b1000000;
            else if (idx == 5 && d == 0) e_seg = 7'b0000000;
            else                      e_seg = SEGTAB[d];
            e_dp = (idx == 4 || idx == 2) && (ss % 2 == 0);
        end
        if (rst) begin
            n = 0; sh = 0; sm = 0; ss = 0; serr = 1'b0;
        end else begin
            n++;
            if (ld) begin
                sh = h; sm = m; ss = s;
                serr = (h > 23) || (m > 59) || (s > 59);
            end
        end
        e_err = serr;
        @(posedge Clock);
        #1;
        check("seg",   {1'b0, seg0}, {1'b0, e_seg});
        check("en",    {2'b0, en0},  {2'b0, e_en});
        check("dp",    {7'b0, dp0},  {7'b0, e_dp});
        check("err",   {7'b0, err0}, {7'b0, e_err});
        check("seg_n", {1'b0, seg1}, {1'b0, ~e_seg});
        check("en_n",  {2'b0, en1},  {2'b0, ~e_en});
        check("dp_n",  {7'b0, dp1},  {7'b0, ~e_dp});
        check("err_l", {7'b0, err1}, {7'b0, e_err});
    endtask

    task automatic wait_en(input logic [5:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(1'b0, 1'b0, 0, 0, 0);
            if (en0 == target) found = 1'b1;
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic ld, input int h, input int m,
                                input int s, input logic [5:0] en, input logic [6:0] seg,
                                input logic dp);
        vec_t v;
        v.rst = rst; v.ld = ld; v.h = h; v.m = m; v.s = s;
        v.en = en; v.seg = seg; v.dp = dp;
        return v;
    endfunction

    initial begin
        bit found;
        int scan_digit [6] = '{6, 5, 4, 3, 2, 1};

        // Reset for 3 cycles, load 12:34:56, then one full scan plus wrap.
        for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 0, 0, 0, 6'b0, 7'h00, 0);
        tbl[3] = mk(0, 1, 12, 34, 56, 6'b0, 7'h00, 0);
        for (int s = 0; s <= 6; s++) begin
            int ix;
            ix = s % 6;
            if (s > 0) tbl[3 + 4 * s] = mk(0, 0, 0, 0, 0, 6'b0, 7'h00, 0);
            for (int c = 1; c <= 3; c++) begin
                if (3 + 4 * s + c < 31)
                    tbl[3 + 4 * s + c] = mk(0, 0, 0, 0, 0, 6'(1 << ix),
                                            SEGTAB[scan_digit[ix]], (ix == 4 || ix == 2));
            end
        end

        for (int i = 0; i < 31; i++) begin
            tick(tbl[i].rst, tbl[i].ld, tbl[i].h, tbl[i].m, tbl[i].s);
            check("tbl_seg", {1'b0, seg0}, {1'b0, tbl[i].seg});
            check("tbl_en",  {2'b0, en0},  {2'b0, tbl[i].en});
            check("tbl_dp",  {7'b0, dp0},  {7'b0, tbl[i].dp});
            check("tbl_err", {7'b0, err0}, 8'h00);
        end

        // Leading-zero blanking and blinking separator.
        tick(1'b0, 1'b1, 5, 7, 8);
        wait_en(6'b100000, found);
        check("ht_found", {7'b0, found}, 8'h01);
        check("ht_blank", {1'b0, seg0}, 8'h00);
        wait_en(6'b010000, found);
        check("ho_found", {7'b0, found}, 8'h01);
        check("dp_even",  {7'b0, dp0}, 8'h01);
        tick(1'b0, 1'b1, 5, 7, 9);
        wait_en(6'b010000, found);
        check("dp_odd", {7'b0, dp0}, 8'h00);

        // Out-of-range snapshot shows dashes, then a valid reload clears it.
        tick(1'b0, 1'b1, 24, 0, 0);
        check("err_set", {7'b0, err0}, 8'h01);
        wait_en(6'b000100, found);
        check("dash", {1'b0, seg0}, 8'h40);
        tick(1'b0, 1'b1, 23, 59, 59);
        check("err_clr", {7'b0, err0}, 8'h00);
        wait_en(6'b100000, found);
        check("ht_2", {1'b0, seg0}, 8'h5B);
        wait_en(6'b000001, found);
        check("so_9", {1'b0, seg0}, 8'h6F);

        // Load on the index 5->0 wrap edge.
        for (int i = 0; i < 30; i++) begin
            if ((n % DIV == DIV - 1) && ((n / DIV) % 6 == 5)) break;
            tick(1'b0, 1'b0, 0, 0, 0);
        end
        tick(1'b0, 1'b1, 10, 20, 30);
        tick(1'b0, 1'b0, 0, 0, 0);
        check("wrap_guard", {2'b0, en0}, 8'h00);
        tick(1'b0, 1'b0, 0, 0, 0);
        check("wrap_en",  {2'b0, en0}, 8'h01);
        check("wrap_seg", {1'b0, seg0}, 8'h3F);

        // Reset mid-slot with Load=1: load discarded, scan restarts at index 0.
        tick(1'b0, 1'b0, 0, 0, 0);
        tick(1'b1, 1'b1, 11, 11, 11);
        tick(1'b0, 1'b0, 0, 0, 0);
        check("rst_guard", {2'b0, en0}, 8'h00);
        tick(1'b0, 1'b0, 0, 0, 0);
        check("rst_en",  {2'b0, en0}, 8'h01);
        check("rst_seg", {1'b0, seg0}, 8'h3F);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic r, l;
            int h, m, s;
            r = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                h = $urandom_range(0, 31); m = $urandom_range(0, 63); s = $urandom_range(0, 63);
            end else begin
                h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
            end
            tick(r, l, h, m, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
